// File: rtl/j1_io_pkg.sv
// Shared constants for the J1 I/O UART: register offsets, status bit positions,
// FSM state encodings and the divisor floor.
package j1_io_pkg;

  localparam logic [15:0] REG_TX     = 16'h0000;
  localparam logic [15:0] REG_RX     = 16'h0002;
  localparam logic [15:0] REG_STATUS = 16'h0004;
  localparam logic [15:0] REG_DIV    = 16'h0006;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_IDLE    = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;

  localparam logic [15:0] DIV_MIN = 16'd16;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < DIV_MIN) ? DIV_MIN : value;
  endfunction

endpackage

// File: rtl/j1_io_fifo.sv
// Byte-wide TX FIFO. A push into a full FIFO is dropped even when a pop
// frees a slot in the same cycle.
module j1_io_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/j1_io_uart.sv
// J1 memory-mapped 8N1 UART: four word registers, TX FIFO, and independent
// TX/RX state machines that latch the baud divisor at each start bit.
module j1_io_uart
  import j1_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h6400,
  parameter int          TX_DEPTH  = 8,
  parameter logic [15:0] DIV_RESET = 16'd590
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        io_sel,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  logic hit_tx, hit_rx, hit_stat, hit_div, rx_read;
  logic [15:0] div_reg;
  logic [15:0] status;

  logic       fifo_full, fifo_empty, tx_pop;
  logic [7:0] fifo_rdata;

  tx_state_t  tx_state, tx_next;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_tick;

  rx_state_t  rx_state, rx_next;
  logic [1:0]  rx_sync;
  logic        rxd_s, rxd_prev;
  logic [15:0] rx_cnt, rx_div;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift, rx_hold;
  logic        rx_half, rx_tick, rx_ok, rx_err;
  logic        rx_valid, rx_overrun, frame_err;

  assign hit_tx   = (io_addr == BASE_ADDR + REG_TX);
  assign hit_rx   = (io_addr == BASE_ADDR + REG_RX);
  assign hit_stat = (io_addr == BASE_ADDR + REG_STATUS);
  assign hit_div  = (io_addr == BASE_ADDR + REG_DIV);
  assign io_sel   = hit_tx || hit_rx || hit_stat || hit_div;
  assign rx_read  = io_rd && hit_rx;
  assign rxd_s    = rx_sync[1];

  always_comb begin
    status                = 16'h0000;
    status[ST_TX_FULL]    = fifo_full;
    status[ST_TX_IDLE]    = fifo_empty && (tx_state == TX_IDLE);
    status[ST_RX_VALID]   = rx_valid;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_FRAME_ERR]  = frame_err;
  end

  always_comb begin
    io_din = 16'h0000;
    if (hit_rx)        io_din = {8'h00, rx_hold};
    else if (hit_stat) io_din = status;
    else if (hit_div)  io_din = div_reg;
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i)                div_reg <= DIV_RESET;
    else if (io_wr && hit_div)    div_reg <= clamp_div(io_dout);
  end

  j1_io_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk   (sys_clk_i),
    .rst   (sys_rst_i),
    .push  (io_wr && hit_tx),
    .pop   (tx_pop),
    .wdata (io_dout[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    tx_tick = (tx_cnt == tx_div - 16'd1);
    case (tx_state)
      TX_IDLE:  if (!fifo_empty) begin tx_next = TX_START; tx_pop = 1'b1; end
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) begin
                  if (!fifo_empty) begin tx_next = TX_START; tx_pop = 1'b1; end
                  else tx_next = TX_IDLE;
                end
    endcase
  end

  // uart_txd is registered from the current state, so the line trails the FSM
  // by one clock while every bit still lasts exactly tx_div cycles.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= DIV_RESET;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_next;
      uart_txd <= (tx_state == TX_START) ? 1'b0 :
                  (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
      if (tx_pop) begin
        tx_shift <= fifo_rdata;
        tx_div   <= div_reg;
        tx_cnt   <= '0;
        tx_bit   <= '0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_tick) begin
          tx_cnt <= '0;
          if (tx_state == TX_DATA) begin
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 3'd1;
          end
        end else begin
          tx_cnt <= tx_cnt + 16'd1;
        end
      end
    end
  end

  always_comb begin
    rx_next = rx_state;
    rx_half = (rx_cnt == (rx_div >> 1) - 16'd1);
    rx_tick = (rx_cnt == rx_div - 16'd1);
    rx_ok   = 1'b0;
    rx_err  = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rxd_prev && !rxd_s) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) begin
                  rx_next = RX_IDLE;
                  rx_ok   = rxd_s;
                  rx_err  = !rxd_s;
                end
    endcase
  end

  // rx_div tracks div_reg while idle, freezing the value seen at the start bit.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      rx_state <= RX_IDLE;
      rx_sync  <= 2'b11;
      rxd_prev <= 1'b1;
      rx_cnt   <= '0;
      rx_div   <= DIV_RESET;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      rx_sync  <= {rx_sync[0], uart_rxd};
      rxd_prev <= rxd_s;
      if (rx_state == RX_IDLE) begin
        rx_cnt <= '0;
        rx_bit <= '0;
        rx_div <= div_reg;
      end else if ((rx_state == RX_START && rx_half) ||
                   (rx_state != RX_START && rx_tick)) begin
        rx_cnt <= '0;
        if (rx_state == RX_DATA) begin
          rx_shift <= {rxd_s, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + 16'd1;
      end
    end
  end

  // A byte landing on the same edge as a data read wins over the clear.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      rx_hold    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rx_read) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
        frame_err  <= 1'b0;
      end
      if (rx_ok) begin
        rx_hold  <= rx_shift;
        rx_valid <= 1'b1;
        if (rx_valid && !rx_read) rx_overrun <= 1'b1;
      end
      if (rx_err) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_j1_io_uart.sv
// Directed/randomised bench for j1_io_uart: a line monitor decodes uart_txd into
// bytes, and RX flags are predicted from the frame-level rules.
module tb_j1_io_uart;

  localparam logic [15:0] BASE = 16'h6400;

  logic        sys_clk_i = 1'b0;
  logic        sys_rst_i = 1'b1;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] io_addr = 16'h0000;
  logic [15:0] io_dout = 16'h0000;
  logic [15:0] io_din;
  logic        io_sel;
  logic        uart_rxd = 1'b1;
  logic        uart_txd;

  int checks = 0;
  int errors = 0;
  int cur_div = 16;

  logic [7:0] tx_got[$];
  logic [7:0] tx_exp[$];
  int         mon_bad_stop = 0;

  logic       m_valid = 1'b0, m_over = 1'b0, m_ferr = 1'b0;
  logic [7:0] m_hold = 8'h00;

  j1_io_uart dut (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_addr   (io_addr),
    .io_dout   (io_dout),
    .io_din    (io_din),
    .io_sel    (io_sel),
    .uart_rxd  (uart_rxd),
    .uart_txd  (uart_txd)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  // Decode each frame on uart_txd by sampling bit centres at the bench's divisor.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge uart_txd);
      repeat (cur_div / 2) @(negedge sys_clk_i);
      for (int i = 0; i < 8; i++) begin
        repeat (cur_div) @(negedge sys_clk_i);
        b[i] = uart_txd;
      end
      repeat (cur_div) @(negedge sys_clk_i);
      if (uart_txd !== 1'b1) mon_bad_stop++;
      tx_got.push_back(b);
    end
  end

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge sys_clk_i);
    io_addr = a; io_dout = d; io_wr = 1'b1;
    @(negedge sys_clk_i);
    io_wr = 1'b0;
  endtask

  task automatic apply_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge sys_clk_i);
    io_addr = a; io_rd = 1'b1;
    #1 d = io_din;
    @(negedge sys_clk_i);
    io_rd = 1'b0;
  endtask

  task automatic peek(input logic [15:0] a, output logic [15:0] d);
    io_addr = a;
    #1 d = io_din;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge sys_clk_i);
    uart_rxd = 1'b0;
    repeat (cur_div) @(negedge sys_clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (cur_div) @(negedge sys_clk_i);
    end
    uart_rxd = stop_bit;
    repeat (cur_div) @(negedge sys_clk_i);
    uart_rxd = 1'b1;
    repeat (cur_div) @(negedge sys_clk_i);
    if (stop_bit) begin
      if (m_valid) m_over = 1'b1;
      m_valid = 1'b1;
      m_hold  = b;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic read_rx_and_model(input string tag);
    logic [15:0] d;
    apply_read(BASE + 16'h2, d);
    check_output(tag, d, {8'h00, m_hold});
    m_valid = 1'b0; m_over = 1'b0; m_ferr = 1'b0;
  endtask

  function automatic logic [15:0] exp_status(input logic idle, input logic full);
    return {11'b0, m_ferr, m_over, m_valid, idle, full};
  endfunction

  initial begin
    logic [15:0] d;
    logic [7:0]  b0;
    logic [7:0]  nine [9];
    logic [9:0]  frame;
    int          n;

    repeat (3) @(negedge sys_clk_i);
    sys_rst_i = 1'b0;

    check_output("reset_txd", {15'b0, uart_txd}, 16'h0001);
    peek(BASE + 16'h4, d);  check_output("reset_status", d, 16'h0002);
    peek(BASE + 16'h6, d);  check_output("reset_div", d, 16'd590);
    peek(BASE + 16'h8, d);  check_output("unmapped_din", d, 16'h0000);
    check_output("unmapped_sel", {15'b0, io_sel}, 16'h0000);
    peek(BASE + 16'h0, d);
    check_output("tx_reg_reads_zero", d, 16'h0000);
    check_output("tx_reg_sel", {15'b0, io_sel}, 16'h0001);

    apply_write(BASE + 16'h6, 16'd15);
    peek(BASE + 16'h6, d);  check_output("div_clamp_15", d, 16'd16);
    apply_write(BASE + 16'h6, 16'd17);
    peek(BASE + 16'h6, d);  check_output("div_17", d, 16'd17);
    apply_write(BASE + 16'h6, 16'd16);
    cur_div = 16;
    peek(BASE + 16'h6, d);  check_output("div_16", d, 16'd16);

    // 8'hA5 frame: start, LSB-first data, stop; bits checked at both ends.
    frame = {1'b1, 8'hA5, 1'b0};
    apply_write(BASE, 16'h00A5);
    @(posedge sys_clk_i); #1;
    check_output("a5_txd_first_edge", {15'b0, uart_txd}, 16'h0001);
    peek(BASE + 16'h4, d);  check_output("a5_busy", d & 16'h0002, 16'h0000);
    @(posedge sys_clk_i); #1;
    for (int k = 0; k < 10; k++) begin
      check_output($sformatf("a5_bit%0d_early", k), {15'b0, uart_txd}, {15'b0, frame[k]});
      repeat (15) @(posedge sys_clk_i);
      #1 check_output($sformatf("a5_bit%0d_late", k), {15'b0, uart_txd}, {15'b0, frame[k]});
      @(posedge sys_clk_i); #1;
    end
    peek(BASE + 16'h4, d);  check_output("a5_idle_after_160", d, 16'h0002);
    repeat (20) @(negedge sys_clk_i);

    // Nine writes while the transmitter is busy; only eight fit.
    tx_got.delete();
    tx_exp.delete();
    b0 = 8'($urandom);
    tx_exp.push_back(b0);
    apply_write(BASE, {8'h00, b0});
    repeat (3) @(negedge sys_clk_i);
    for (int i = 0; i < 9; i++) begin
      nine[i] = 8'($urandom);
      apply_write(BASE, {8'h00, nine[i]});
      if (i < 8) tx_exp.push_back(nine[i]);
      peek(BASE + 16'h4, d);
      if (i == 6) check_output("full_after_7", d & 16'h0001, 16'h0000);
      if (i == 7) check_output("full_after_8", d & 16'h0001, 16'h0001);
      if (i == 8) check_output("full_after_9", d & 16'h0001, 16'h0001);
    end
    n = 0;
    while (n < 3000 && tx_got.size() < 9) begin
      @(negedge sys_clk_i);
      n++;
    end
    check_output("nine_frames_timeout", {15'b0, (tx_got.size() >= 9)}, 16'h0001);
    repeat (30) @(negedge sys_clk_i);
    check_output("tx_frame_count", 16'(tx_got.size()), 16'(tx_exp.size()));
    for (int i = 0; i < tx_exp.size() && i < tx_got.size(); i++)
      check_output($sformatf("tx_byte%0d", i), {8'h00, tx_got[i]}, {8'h00, tx_exp[i]});
    check_output("tx_stop_bits", 16'(mon_bad_stop), 16'h0000);
    peek(BASE + 16'h4, d);  check_output("tx_idle_after_burst", d, 16'h0002);

    // RX: directed 8'h3C.
    send_rx(8'h3C, 1'b1);
    peek(BASE + 16'h4, d);  check_output("rx_3c_status", d, exp_status(1'b1, 1'b0));
    read_rx_and_model("rx_3c_data");
    peek(BASE + 16'h4, d);  check_output("rx_3c_cleared", d, exp_status(1'b1, 1'b0));

    // RX: two random frames without a read in between.
    send_rx(8'($urandom), 1'b1);
    send_rx(8'($urandom), 1'b1);
    peek(BASE + 16'h4, d);  check_output("rx_overrun_status", d, exp_status(1'b1, 1'b0));
    read_rx_and_model("rx_overrun_data");

    // RX: stop bit low; held byte must not change.
    send_rx(8'($urandom), 1'b0);
    peek(BASE + 16'h4, d);  check_output("rx_frame_err_status", d, exp_status(1'b1, 1'b0));
    read_rx_and_model("rx_frame_err_hold");
    peek(BASE + 16'h4, d);  check_output("rx_frame_err_cleared", d, exp_status(1'b1, 1'b0));

    // Both directions at a new divisor.
    apply_write(BASE + 16'h6, 16'd24);
    cur_div = 24;
    send_rx(8'($urandom), 1'b1);
    peek(BASE + 16'h4, d);  check_output("rx_div24_status", d, exp_status(1'b1, 1'b0));
    read_rx_and_model("rx_div24_data");
    tx_got.delete();
    b0 = 8'($urandom);
    apply_write(BASE, {8'h00, b0});
    n = 0;
    while (n < 1000 && tx_got.size() < 1) begin
      @(negedge sys_clk_i);
      n++;
    end
    check_output("tx_div24_timeout", {15'b0, (tx_got.size() >= 1)}, 16'h0001);
    if (tx_got.size() >= 1) check_output("tx_div24_byte", {8'h00, tx_got[0]}, {8'h00, b0});
    repeat (30) @(negedge sys_clk_i);

    // Writes to unmapped and read-only registers.
    apply_write(BASE + 16'h8, 16'h1234);
    apply_write(BASE + 16'h1, 16'h0040);
    apply_write(BASE + 16'h4, 16'hFFFF);
    apply_write(BASE + 16'h2, 16'h0055);
    peek(BASE + 16'h6, d);  check_output("div_after_unmapped", d, 16'd24);
    peek(BASE + 16'h4, d);  check_output("status_after_ro_write", d, 16'h0002);
    peek(BASE + 16'h2, d);  check_output("rx_after_ro_write", d, {8'h00, m_hold});
    peek(BASE + 16'h1, d);  check_output("odd_addr_sel", {15'b0, io_sel}, 16'h0000);

    // Reset in the middle of a start bit with more bytes queued.
    apply_write(BASE, 16'h0000);
    apply_write(BASE, 16'h00FF);
    apply_write(BASE, 16'h0011);
    n = 0;
    while (n < 200 && uart_txd !== 1'b0) begin
      @(negedge sys_clk_i);
      n++;
    end
    repeat (3) @(negedge sys_clk_i);
    check_output("pre_reset_txd_low", {15'b0, uart_txd}, 16'h0000);
    #2 sys_rst_i = 1'b1;
    #1 check_output("async_reset_txd", {15'b0, uart_txd}, 16'h0001);
    peek(BASE + 16'h4, d);  check_output("reset_fifo_empty", d, 16'h0002);
    peek(BASE + 16'h6, d);  check_output("reset_div_590", d, 16'd590);
    repeat (3) @(negedge sys_clk_i);
    check_output("txd_held_in_reset", {15'b0, uart_txd}, 16'h0001);
    sys_rst_i = 1'b0;
    repeat (50) @(negedge sys_clk_i);
    check_output("txd_after_reset", {15'b0, uart_txd}, 16'h0001);
    peek(BASE + 16'h4, d);  check_output("status_after_reset", d, 16'h0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
